branch_res_handler: RTL

// - Fetch-side consumer of the branch unit resolution_t stream.
// - On a mispredict, issues a one-cycle flush/redirect to fetch.
// - Keeps a 2-bit saturating-counter branch history table (BHT):

---
 rtl/branch_res_handler_pkg.sv | 38 +++
 rtl/branch_res_handler_bht_table.sv | 35 +++
 rtl/branch_res_handler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/branch_res_handler_pkg.sv
// Shared types for the branch resolution handler: the resolution stream
// from the branch unit, BHT counter type/constants and the FSM state enum.
package branch_res_handler_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic            valid;
      logic            taken;
      logic            mispredict;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
   } resolution_t;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t BHT_CTR_INIT = 2'b01;
   localparam bht_ctr_t BHT_CTR_MAX  = 2'b11;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      UPDATE
   } bht_state_t;

   // Saturating 2-bit counter step; never wraps past 0 or BHT_CTR_MAX.
   function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != BHT_CTR_MAX) nxt = ctr + bht_ctr_t'(1);
      end else begin
         if (ctr != bht_ctr_t'(0)) nxt = ctr - bht_ctr_t'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_res_handler_bht_table.sv
// Branch history table: flop array of 2-bit saturating counters with one
// combinational read port and one read-modify-write port. The write port
// either stores the init value (table sweep) or applies a training step.
module bht_table
   import branch_res_handler_pkg::*;
#(
   parameter int       IDX_W    = 6,
   parameter bht_ctr_t CNT_INIT = BHT_CTR_INIT
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output bht_ctr_t         rd_ctr_o,
   input  logic             wr_en_i,
   input  logic             wr_init_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   localparam int NUM_ENT = 1 << IDX_W;

   bht_ctr_t mem_q [NUM_ENT];

   // Counter storage: cleared on reset, written by init sweep or training.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_ENT; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_init_i ? CNT_INIT : bht_ctr_next(mem_q[wr_idx_i], wr_taken_i);
      end
   end

   assign rd_ctr_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_res_handler.sv
// Fetch-side consumer of branch resolutions: registered flush/redirect on
// mispredict, one-entry pending buffer feeding BHT training, and a
// saturating count of training updates lost while the buffer was busy.
//
//   state  | meaning
//   INIT   | sweeping the table with the init value, one entry per cycle
//   IDLE   | waiting for a buffered training update
//   UPDATE | applying the buffered update to its counter
module branch_res_handler
   import branch_res_handler_pkg::*;
#(
   parameter int       IDX_W    = 6,
   parameter bht_ctr_t CNT_INIT = BHT_CTR_INIT,
   parameter int       DROP_W   = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  resolution_t       res_i,
   input  logic [XLEN-1:0]   pred_pc_i,
   output logic              pred_taken_o,
   output logic              flush_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic              init_done_o,
   output logic [DROP_W-1:0] drop_cnt_o
);

   bht_state_t        state_q;
   logic [IDX_W-1:0]  idx_q;
   logic              init_done_q;
   logic              pend_vld_q;
   logic [IDX_W-1:0]  pend_idx_q;
   logic              pend_taken_q;
   logic [DROP_W-1:0] drop_q;
   logic              flush_q;
   logic              flush_d;
   logic [XLEN-1:0]   redir_q;
   logic [XLEN-1:0]   redir_d;
   logic              drain;
   logic              capture;
   logic              drop;
   bht_ctr_t          rd_ctr;
   logic              unused_bits;

   // The buffer empties whenever UPDATE consumes it, so a new resolution
   // arriving that same cycle can take its place without being lost.
   assign drain   = (state_q == UPDATE);
   assign capture = res_i.valid & (~pend_vld_q | drain);
   assign drop    = res_i.valid & pend_vld_q & ~drain;

   // Redirect target, derived directly from the resolution stream.
   always_comb begin
      flush_d = res_i.valid & res_i.mispredict;
      redir_d = '0;
      if (flush_d) redir_d = res_i.taken ? res_i.target : res_i.pc + XLEN'(4);
   end

   // Flush pulse and redirect PC, registered for one cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         flush_q <= 1'b0;
         redir_q <= '0;
      end else begin
         flush_q <= flush_d;
         redir_q <= redir_d;
      end
   end

   // Single-entry training buffer.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_vld_q   <= 1'b0;
         pend_idx_q   <= '0;
         pend_taken_q <= 1'b0;
      end else if (capture) begin
         pend_vld_q   <= 1'b1;
         pend_idx_q   <= res_i.pc[IDX_W+1:2];
         pend_taken_q <= res_i.taken;
      end else if (drain) begin
         pend_vld_q   <= 1'b0;
      end
   end

   // Saturating count of training updates lost to a full buffer.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         drop_q <= '0;
      end else if (drop && (drop_q != {DROP_W{1'b1}})) begin
         drop_q <= drop_q + DROP_W'(1);
      end
   end

   // Table sweep and training sequencer.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= INIT;
         idx_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            INIT: begin
               idx_q <= idx_q + IDX_W'(1);
               if (idx_q == {IDX_W{1'b1}}) begin
                  state_q     <= IDLE;
                  init_done_q <= 1'b1;
               end
            end
            IDLE: begin
               if (pend_vld_q) state_q <= UPDATE;
            end
            UPDATE: begin
               state_q <= capture ? UPDATE : IDLE;
            end
            default: state_q <= INIT;
         endcase
      end
   end

   bht_table #(
      .IDX_W    (IDX_W),
      .CNT_INIT (CNT_INIT)
   ) u_bht (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .rd_idx_i   (pred_pc_i[IDX_W+1:2]),
      .rd_ctr_o   (rd_ctr),
      .wr_en_i    ((state_q == INIT) | drain),
      .wr_init_i  (state_q == INIT),
      .wr_idx_i   ((state_q == INIT) ? idx_q : pend_idx_q),
      .wr_taken_i (pend_taken_q)
   );

   assign unused_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0],
                          res_i.pc[XLEN-1:IDX_W+2], res_i.pc[1:0], rd_ctr[0]};

   assign pred_taken_o  = init_done_q & rd_ctr[1];
   assign flush_o       = flush_q;
   assign redirect_pc_o = redir_q;
   assign init_done_o   = init_done_q;
   assign drop_cnt_o    = drop_q;

endmodule
